// File: rtl/a2d_rr_sched.sv
// Round-robin A2D conversion scheduler: each request performs a command/read
// SPI transfer pair for the next of four slots and latches the 12-bit result.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for a request (nxt input or pending flag)
// S_CMD    | issue channel command transfer (wrt pulse)
// S_WAIT_C | wait for command transfer done, with timeout
// S_GAP    | idle spacing before the read transfer
// S_RD     | issue read transfer (wrt pulse, all-zero word)
// S_WAIT_R | wait for read transfer done, capture result, with timeout
// S_LATCH  | announce the new result (upd), advance slot pointer
module a2d_rr_sched #(
    parameter logic [2:0] CH_LFT   = 3'd0,
    parameter logic [2:0] CH_RGHT  = 3'd4,
    parameter logic [2:0] CH_STEER = 3'd5,
    parameter logic [2:0] CH_BATT  = 3'd6,
    parameter int         GAP_CYC  = 4,
    parameter int         TIMEOUT  = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_nxt,
    output logic        o_wrt,
    output logic [15:0] o_wt_data,
    input  logic        i_done,
    input  logic [15:0] i_rd_data,
    output logic [11:0] o_lft_ld,
    output logic [11:0] o_rght_ld,
    output logic [11:0] o_steer_pot,
    output logic [11:0] o_batt,
    output logic        o_upd,
    output logic [1:0]  o_upd_slot,
    output logic        o_busy,
    output logic        o_timeout_err
);

    localparam int CNT_MAX = (TIMEOUT > GAP_CYC) ? TIMEOUT : GAP_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] TO_LD  = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WAIT_C,
        S_GAP,
        S_RD,
        S_WAIT_R,
        S_LATCH
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]    r_ptr, w_ptr_nxt;
    logic          r_pend, w_pend_nxt;
    logic          r_terr, w_terr_nxt;
    logic          w_ld_en;
    logic [2:0]    w_ch;
    logic [15:0]   w_cmd_word;
    logic [11:0]   r_lft, r_rght, r_steer, r_batt;
    logic          w_unused;

    assign w_unused = ^i_rd_data[15:12];

    always_comb begin
        case (r_ptr)
            2'd0:    w_ch = CH_LFT;
            2'd1:    w_ch = CH_RGHT;
            2'd2:    w_ch = CH_STEER;
            default: w_ch = CH_BATT;
        endcase
    end

    assign w_cmd_word = {2'b00, w_ch, 11'h000};

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_pend_nxt  = r_pend | i_nxt;
        w_terr_nxt  = r_terr;
        w_ld_en     = 1'b0;
        o_wrt       = 1'b0;
        o_wt_data   = 16'h0000;
        o_upd       = 1'b0;
        o_upd_slot  = 2'd0;
        case (r_state)
            S_IDLE: begin
                if (i_nxt || r_pend) begin
                    w_state_nxt = S_CMD;
                    w_pend_nxt  = 1'b0;
                end
            end
            S_CMD: begin
                o_wrt       = 1'b1;
                o_wt_data   = w_cmd_word;
                w_cnt_nxt   = TO_LD;
                w_state_nxt = S_WAIT_C;
            end
            S_WAIT_C: begin
                o_wt_data = w_cmd_word;
                if (i_done) begin
                    w_cnt_nxt   = GAP_LD;
                    w_state_nxt = S_GAP;
                end else if (r_cnt == '0) begin
                    w_terr_nxt  = 1'b1;
                    w_ptr_nxt   = r_ptr + 2'd1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_GAP: begin
                if (r_cnt == '0) w_state_nxt = S_RD;
                else             w_cnt_nxt   = r_cnt - CW'(1);
            end
            S_RD: begin
                o_wrt       = 1'b1;
                w_cnt_nxt   = TO_LD;
                w_state_nxt = S_WAIT_R;
            end
            S_WAIT_R: begin
                if (i_done) begin
                    w_ld_en     = 1'b1;
                    w_state_nxt = S_LATCH;
                end else if (r_cnt == '0) begin
                    w_terr_nxt  = 1'b1;
                    w_ptr_nxt   = r_ptr + 2'd1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_LATCH: begin
                o_upd       = 1'b1;
                o_upd_slot  = r_ptr;
                w_ptr_nxt   = r_ptr + 2'd1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_busy        = (r_state != S_IDLE);
    assign o_timeout_err = r_terr;
    assign o_lft_ld      = r_lft;
    assign o_rght_ld     = r_rght;
    assign o_steer_pot   = r_steer;
    assign o_batt        = r_batt;

    // Result is written on the done edge so it is already valid while upd is high.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ptr   <= 2'd0;
            r_pend  <= 1'b0;
            r_terr  <= 1'b0;
            r_lft   <= 12'h000;
            r_rght  <= 12'h000;
            r_steer <= 12'h000;
            r_batt  <= 12'h000;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_pend  <= w_pend_nxt;
            r_terr  <= w_terr_nxt;
            if (w_ld_en) begin
                case (r_ptr)
                    2'd0:    r_lft   <= i_rd_data[11:0];
                    2'd1:    r_rght  <= i_rd_data[11:0];
                    2'd2:    r_steer <= i_rd_data[11:0];
                    default: r_batt  <= i_rd_data[11:0];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_a2d_rr_sched.sv
// Scoreboard bench for a2d_rr_sched: an SPI master model answers transfers,
// expected command words and results are queued as requests are issued.
module tb_a2d_rr_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        nxt = 1'b0;
    logic        done = 1'b0;
    logic [15:0] rd_data = 16'h0000;
    logic        wrt, upd, busy, terr;
    logic [15:0] wt_data;
    logic [11:0] lft_ld, rght_ld, steer_pot, batt;
    logic [1:0]  upd_slot;

    a2d_rr_sched dut (
        .i_clk(clk), .i_rst(rst), .i_nxt(nxt),
        .o_wrt(wrt), .o_wt_data(wt_data),
        .i_done(done), .i_rd_data(rd_data),
        .o_lft_ld(lft_ld), .o_rght_ld(rght_ld), .o_steer_pot(steer_pot), .o_batt(batt),
        .o_upd(upd), .o_upd_slot(upd_slot), .o_busy(busy), .o_timeout_err(terr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  slot;
        logic [11:0] val;
    } upd_t;

    localparam logic [2:0] CH_TAB [4] = '{3'd0, 3'd4, 3'd5, 3'd6};

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [15:0] exp_cmd_q [$];
    upd_t        exp_upd_q [$];
    logic [11:0] shadow [4] = '{12'h0, 12'h0, 12'h0, 12'h0};
    logic [1:0]  bp = 2'd0;
    bit          abc_mode = 1'b0;
    bit          hold_all = 1'b0;
    bit          hold_rd = 1'b0;
    bit          outst = 1'b0;
    int          phase = 0;
    int          dl = 0;
    int          last_done_cyc = 0;
    bit          chk_regs = 1'b0;
    int          n_upd = 0;
    logic [2:0]  cur_ch = 3'd0;
    logic [15:0] cur_word = 16'h0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [11:0] mdl_val(input logic [2:0] ch);
        logic [11:0] v;
        v = {9'd0, ch};
        if (abc_mode && ch == 3'd0) return 12'hABC;
        return v * 12'h111;
    endfunction

    // SPI master model plus output monitor
    initial begin
        upd_t e;
        logic [15:0] ec;
        forever begin
            @(negedge clk);
            cyc++;
            if (chk_regs) begin
                chk("reg_lft", lft_ld, shadow[0]);
                chk("reg_rght", rght_ld, shadow[1]);
                chk("reg_steer", steer_pot, shadow[2]);
                chk("reg_batt", batt, shadow[3]);
                chk_regs = 1'b0;
            end
            done = 1'b0;
            if (rst || !busy) begin
                outst = 1'b0; phase = 0; dl = 0;
            end else if (dl > 0) begin
                dl--;
                if (dl == 0) begin
                    chk("wt_hold", wt_data, cur_word);
                    done  = 1'b1;
                    outst = 1'b0;
                    if (phase == 1) begin
                        rd_data = 16'hDEAD;
                        last_done_cyc = cyc;
                    end else begin
                        rd_data = {4'hF, mdl_val(cur_ch)};
                    end
                end
            end
            if (wrt) begin
                if (outst) chk("wrt_overlap", 1, 0);
                if (phase == 0) begin
                    if (exp_cmd_q.size() == 0) begin
                        chk("cmd_unexpected", 1, 0);
                    end else begin
                        ec = exp_cmd_q.pop_front();
                        chk("cmd_word", wt_data, ec);
                    end
                    cur_ch = wt_data[13:11];
                    phase  = 1;
                    if (!hold_all) dl = 3;
                end else begin
                    chk("rd_word", wt_data, 16'h0000);
                    chk("gap_clks", cyc - last_done_cyc, 5);
                    phase = 2;
                    if (!hold_all && !hold_rd) dl = 3;
                end
                cur_word = wt_data;
                outst = 1'b1;
            end
            if (upd) begin
                n_upd++;
                if (exp_upd_q.size() == 0) begin
                    chk("upd_unexpected", 1, 0);
                end else begin
                    e = exp_upd_q.pop_front();
                    chk("upd_slot", upd_slot, e.slot);
                    shadow[e.slot] = e.val;
                    chk_regs = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_conv();
        exp_cmd_q.push_back({2'b00, CH_TAB[bp], 11'h000});
        exp_upd_q.push_back('{slot: bp, val: mdl_val(CH_TAB[bp])});
        bp = bp + 2'd1;
    endtask

    task automatic pulse_nxt();
        nxt = 1'b1;
        tick();
        nxt = 1'b0;
    endtask

    task automatic do_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bp = 2'd0;
        for (int i = 0; i < 4; i++) shadow[i] = 12'h000;
        exp_cmd_q.delete();
        exp_upd_q.delete();
    endtask

    task automatic wait_quiet(input int budget);
        int k;
        k = 0;
        while ((busy || exp_upd_q.size() != 0) && k < budget) begin
            tick();
            k++;
        end
        chk("idle_reached", (k < budget), 1);
        tick();
        tick();
    endtask

    initial begin
        int k;
        int u0;
        logic seen;
        tick();
        do_rst();

        // reset state
        chk("rst_wrt", wrt, 0);
        chk("rst_wt_data", wt_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_upd", upd, 0);
        chk("rst_terr", terr, 0);
        chk("rst_lft", lft_ld, 0);

        // single conversion, slot 0, with latency check
        abc_mode = 1'b1;
        push_conv();
        pulse_nxt();
        chk("lat_wrt", wrt, 1);
        chk("lat_busy", busy, 1);
        wait_quiet(100);
        chk("t1_lft", lft_ld, 12'hABC);
        abc_mode = 1'b0;

        // full rotation plus wrap back to slot 0
        do_rst();
        for (int i = 0; i < 5; i++) begin
            push_conv();
            pulse_nxt();
            wait_quiet(100);
        end
        chk("rot_rght", rght_ld, 12'h444);
        chk("rot_batt", batt, 12'h666);

        // three back-to-back requests: one runs, one pends, one dropped
        u0 = n_upd;
        push_conv();
        push_conv();
        nxt = 1'b1;
        tick(); tick(); tick();
        nxt = 1'b0;
        wait_quiet(200);
        chk("burst_upd_cnt", n_upd - u0, 2);
        chk("burst_cmd_left", exp_cmd_q.size(), 0);

        // request arriving during LATCH becomes pending
        u0 = n_upd;
        push_conv();
        push_conv();
        pulse_nxt();
        k = 0;
        while (!upd && k < 100) begin tick(); k++; end
        chk("latch_seen", upd, 1);
        nxt = 1'b1;
        tick();
        nxt = 1'b0;
        chk("latch_idle_busy", busy, 0);
        tick();
        chk("latch_pend_wrt", wrt, 1);
        wait_quiet(200);
        chk("latch_upd_cnt", n_upd - u0, 2);

        // done withheld on slot 0 -> timeout, then slot 1 converts
        do_rst();
        hold_all = 1'b1;
        exp_cmd_q.push_back({2'b00, CH_TAB[0], 11'h000});
        bp = 2'd1;
        u0 = n_upd;
        pulse_nxt();
        k = 0;
        while (!terr && k < 1200) begin tick(); k++; end
        chk("to_set", terr, 1);
        chk("to_window", (k >= 1020 && k <= 1030), 1);
        chk("to_busy", busy, 0);
        chk("to_no_upd", n_upd - u0, 0);
        chk("to_lft_kept", lft_ld, 12'h000);
        hold_all = 1'b0;
        push_conv();
        pulse_nxt();
        wait_quiet(100);
        chk("to_next_rght", rght_ld, 12'h444);
        chk("to_sticky", terr, 1);

        // reset while waiting on the read transfer
        hold_rd = 1'b1;
        exp_cmd_q.push_back({2'b00, CH_TAB[bp], 11'h000});
        pulse_nxt();
        k = 0;
        while (!(wrt && wt_data == 16'h0000) && k < 50) begin tick(); k++; end
        chk("rd_wrt_seen", wrt, 1);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bp = 2'd0;
        for (int i = 0; i < 4; i++) shadow[i] = 12'h000;
        exp_upd_q.delete();
        hold_rd = 1'b0;
        chk("rr_wrt", wrt, 0);
        chk("rr_wt_data", wt_data, 0);
        chk("rr_busy", busy, 0);
        chk("rr_terr", terr, 0);
        chk("rr_upd", upd, 0);
        chk("rr_upd_slot", upd_slot, 0);
        chk("rr_lft", lft_ld, 0);
        chk("rr_rght", rght_ld, 0);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen = seen | wrt;
        end
        chk("rr_wrt_quiet", seen, 0);
        push_conv();
        pulse_nxt();
        wait_quiet(100);
        chk("rr_q_empty", exp_cmd_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
